// File: rtl/vol_meter_pkg.sv
// ---------------------------------------------------------------------------
// vol_meter_pkg
// Shared definitions for the volume-meter family: RGB565 colour constants,
// the level index type and the quantiser step calculation.
// ---------------------------------------------------------------------------
package vol_meter_pkg;

    // Bar / peak level index, 0..15
    typedef logic [3:0] level_t;

    // RGB565 colours used by the renderer
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] WHITE  = 16'hFFFF;

    // Width of one bar segment in magnitude units: the full magnitude range
    // split into N_LEVELS+1 bands, floored.
    function automatic int unsigned calc_step(input int unsigned mag_w,
                                              input int unsigned n_levels);
        return (32'd1 << mag_w) / (n_levels + 32'd1);
    endfunction

endpackage

// File: rtl/vol_meter_peak_oled_if.sv
// ---------------------------------------------------------------------------
// vol_meter_peak_oled_if
// Bundles the sample stream, the OLED pixel coordinate/colour pair and the
// meter status outputs of vol_meter_peak_oled.
//   sample_valid, sample : magnitude sample strobe and value (source -> meter)
//   x, y                 : current OLED pixel coordinate    (display -> meter)
//   oled_data            : RGB565 colour for (x, y)         (meter -> display)
//   bar_level            : displayed bar level
//   peak_level           : peak marker level
//   update_pulse         : one-cycle strobe when new levels become visible
// Modports: master = sample source / display driver, slave = the meter.
// ---------------------------------------------------------------------------
interface vol_meter_peak_oled_if
    import vol_meter_pkg::*;
#(
    parameter int MAG_W = 11
);
    logic             sample_valid;
    logic [MAG_W-1:0] sample;
    logic [6:0]       x;
    logic [6:0]       y;
    logic [15:0]      oled_data;
    level_t           bar_level;
    level_t           peak_level;
    logic             update_pulse;

    modport master (
        output sample_valid, sample, x, y,
        input  oled_data, bar_level, peak_level, update_pulse
    );

    modport slave (
        input  sample_valid, sample, x, y,
        output oled_data, bar_level, peak_level, update_pulse
    );
endinterface

// File: rtl/vol_level_quant.sv
// ---------------------------------------------------------------------------
// vol_level_quant
// Purely combinational magnitude -> bar level quantiser.
//   mag   : unsigned magnitude
//   level : min(floor(mag / STEP), N_LEVELS)
// Uses N_LEVELS parallel threshold compares instead of a divider; the
// thresholds rise monotonically, so the highest passing compare wins and the
// result saturates at N_LEVELS by construction.
// ---------------------------------------------------------------------------
module vol_level_quant
    import vol_meter_pkg::*;
#(
    parameter int MAG_W    = 11,
    parameter int N_LEVELS = 9
) (
    input  logic [MAG_W-1:0] mag,
    output level_t           level
);
    localparam int unsigned STEP = calc_step(MAG_W, N_LEVELS);

    always_comb begin
        level = '0;
        for (int k = 1; k <= N_LEVELS; k++) begin
            if (32'(mag) >= 32'(k * STEP)) begin
                level = level_t'(k);
            end
        end
    end

endmodule

// File: rtl/vol_meter_peak_oled.sv
// ---------------------------------------------------------------------------
// vol_meter_peak_oled
// Peak-hold bar volume meter rendered onto a 96x64 RGB565 OLED stream.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : vol_meter_peak_oled_if slave port
//                (sample_valid/sample in, x/y in, oled_data out,
//                 bar_level/peak_level/update_pulse out)
// Tracks the maximum sample over each UPDATE_DIV-cycle window, quantises it
// to a bar level with instant attack and one-level-per-update decay, and
// keeps a peak marker that holds for HOLD_UPDATES updates before decaying.
// The pixel colour is combinational from (x, y) and the registered levels.
// ---------------------------------------------------------------------------
module vol_meter_peak_oled
    import vol_meter_pkg::*;
#(
    parameter int MAG_W        = 11,
    parameter int N_LEVELS     = 9,
    parameter int UPDATE_DIV   = 2_000_000,
    parameter int HOLD_UPDATES = 10,
    parameter int X_LO         = 32,
    parameter int X_HI         = 63,
    parameter int Y_BOTTOM     = 63,
    parameter int SEG_H        = 6,
    parameter int SEG_PITCH    = 7,
    parameter int GREEN_TOP    = 3,
    parameter int YELLOW_TOP   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    vol_meter_peak_oled_if.slave  bus
);
    localparam int DIV_W  = $clog2(UPDATE_DIV);
    localparam int HOLD_W = (HOLD_UPDATES < 1) ? 1 : $clog2(HOLD_UPDATES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_UPDATES);

    logic [DIV_W-1:0]  div_cnt;
    logic [MAG_W-1:0]  win_max;
    logic [MAG_W-1:0]  m_close;
    level_t            q_level;
    level_t            bar_q,   bar_nxt;
    level_t            peak_q,  peak_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              update_cycle;
    logic              update_pulse_q;

    assign update_cycle = (div_cnt == DIV_LAST);

    // Window maximum as it stands on the closing cycle, including a sample
    // that lands on that very cycle.
    assign m_close = (bus.sample_valid && (bus.sample > win_max)) ? bus.sample : win_max;

    vol_level_quant #(
        .MAG_W    (MAG_W),
        .N_LEVELS (N_LEVELS)
    ) u_quant (
        .mag   (m_close),
        .level (q_level)
    );

    // Meter update rules: bar attacks instantly and decays by one per update;
    // the peak marker re-arms its hold on any level at or above it, otherwise
    // burns hold time before decaying. Together these keep peak >= bar.
    always_comb begin
        bar_nxt  = bar_q;
        peak_nxt = peak_q;
        hold_nxt = hold_cnt;
        if (update_cycle) begin
            if (q_level >= bar_q) begin
                bar_nxt = q_level;
            end else begin
                bar_nxt = bar_q - 4'd1;
            end

            if (q_level >= peak_q) begin
                peak_nxt = q_level;
                hold_nxt = HOLD_INIT;
            end else if (hold_cnt != '0) begin
                hold_nxt = hold_cnt - HOLD_W'(1);
            end else if (peak_q != '0) begin
                peak_nxt = peak_q - 4'd1;
            end
        end
    end

    // ---- Registered meter state (divider, window, levels) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt        <= '0;
            win_max        <= '0;
            bar_q          <= '0;
            peak_q         <= '0;
            hold_cnt       <= '0;
            update_pulse_q <= 1'b0;
        end else begin
            update_pulse_q <= update_cycle;
            bar_q          <= bar_nxt;
            peak_q         <= peak_nxt;
            hold_cnt       <= hold_nxt;
            if (update_cycle) begin
                div_cnt <= '0;
                win_max <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                if (bus.sample_valid && (bus.sample > win_max)) begin
                    win_max <= bus.sample;
                end
            end
        end
    end

    assign bus.bar_level    = bar_q;
    assign bus.peak_level   = peak_q;
    assign bus.update_pulse = update_pulse_q;

    // ---- Pixel renderer (combinational) ----
    int x_i;
    int y_i;
    assign x_i = int'(bus.x);
    assign y_i = int'(bus.y);

    logic [N_LEVELS:1] row_hit;

    for (genvar k = 1; k <= N_LEVELS; k++) begin : g_seg
        localparam int SEG_BOT = Y_BOTTOM - (k - 1) * SEG_PITCH;
        localparam int SEG_TOP = SEG_BOT - SEG_H + 1;
        assign row_hit[k] = (y_i >= SEG_TOP) && (y_i <= SEG_BOT);
    end

    level_t seg;

    // Segment under the current pixel, 0 for gaps and out-of-column pixels.
    always_comb begin
        seg = '0;
        if ((x_i >= X_LO) && (x_i <= X_HI)) begin
            for (int k = 1; k <= N_LEVELS; k++) begin
                if (row_hit[k]) begin
                    seg = level_t'(k);
                end
            end
        end
    end

    always_comb begin
        bus.oled_data = BLACK;
        if (seg != '0) begin
            if (seg <= bar_q) begin
                if (seg <= level_t'(GREEN_TOP)) begin
                    bus.oled_data = GREEN;
                end else if (seg <= level_t'(YELLOW_TOP)) begin
                    bus.oled_data = YELLOW;
                end else begin
                    bus.oled_data = RED;
                end
            end else if ((seg == peak_q) && (peak_q > bar_q)) begin
                bus.oled_data = WHITE;
            end
        end
    end

endmodule

// File: tb/tb_vol_meter_peak_oled.sv
module tb_vol_meter_peak_oled;
    localparam int MAG_W        = 11;
    localparam int N_LEVELS     = 9;
    localparam int UPDATE_DIV   = 4;
    localparam int HOLD_UPDATES = 2;
    localparam int STEP         = 2048 / 10;

    typedef struct {
        int bar;
        int peak;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   tb_div;
    int   m_bar, m_peak, m_hold;
    exp_t exp_q[$];

    vol_meter_peak_oled_if #(.MAG_W(MAG_W)) bus();

    vol_meter_peak_oled #(
        .MAG_W        (MAG_W),
        .N_LEVELS     (N_LEVELS),
        .UPDATE_DIV   (UPDATE_DIV),
        .HOLD_UPDATES (HOLD_UPDATES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Reference divider phase: value the DUT counter should hold after each edge
    always @(posedge clk or posedge reset) begin
        if (reset) tb_div <= 0;
        else       tb_div <= (tb_div == UPDATE_DIV - 1) ? 0 : tb_div + 1;
    end

    function automatic int quant(input int m);
        int q;
        q = m / STEP;
        return (q > N_LEVELS) ? N_LEVELS : q;
    endfunction

    function automatic logic [15:0] pix_model(input int px, input int py, input int bar, input int peak);
        int d, k;
        if (px < 32 || px > 63 || py > 63) return 16'h0000;
        d = 63 - py;
        if ((d % 7) >= 6) return 16'h0000;
        k = d / 7 + 1;
        if (k > N_LEVELS) return 16'h0000;
        if (k <= bar) return (k <= 3) ? 16'h07E0 : (k <= 6) ? 16'hFFE0 : 16'hF800;
        if (k == peak && peak > bar) return 16'hFFFF;
        return 16'h0000;
    endfunction

    task automatic model_update(input int m);
        exp_t e;
        int q;
        q = quant(m);
        if (q >= m_bar) m_bar = q; else m_bar = m_bar - 1;
        if (q >= m_peak) begin
            m_peak = q;
            m_hold = HOLD_UPDATES;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else if (m_peak > 0) begin
            m_peak = m_peak - 1;
        end
        e.bar  = m_bar;
        e.peak = m_peak;
        exp_q.push_back(e);
    endtask

    // One full window starting at a negedge where the divider is at 0; the
    // optional sample goes in on the first cycle or on the closing cycle.
    // Returns at the negedge right after the update edge.
    task automatic drive_window(input int val, input bit valid, input bit on_upd);
        for (int p = 0; p < UPDATE_DIV; p++) begin
            if (valid && (on_upd ? (p == UPDATE_DIV - 1) : (p == 0))) begin
                bus.sample_valid = 1'b1;
                bus.sample       = 11'(val);
            end else begin
                bus.sample_valid = 1'b0;
                bus.sample       = '0;
            end
            if (p == UPDATE_DIV - 1) model_update(valid ? val : 0);
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_bar  = 0;
        m_peak = 0;
        m_hold = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bus.x = 7'd40;
        bus.y = 7'd63;
        #1;
        total++;
        if (bus.bar_level !== 4'd0 || bus.peak_level !== 4'd0 || bus.update_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_levels: bar=%0d peak=%0d pulse=%b, want 0 0 0", bus.bar_level, bus.peak_level, bus.update_pulse);
        end
        total++;
        if (bus.oled_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_pixel: oled=%h want 0000", bus.oled_data);
        end
        @(negedge clk);
        reset  = 1'b0;
        m_bar  = 0;
        m_peak = 0;
        m_hold = 0;
    endtask

    task automatic test_quant();
        int   vals[3] = '{203, 204, 2047};
        int   want[3] = '{0, 1, 9};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_window(vals[i], 1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'(want[i]) || bus.peak_level !== 4'(e.peak)) begin
                bad++;
                $display("FAIL quant_%0d: pulse=%b bar=%0d peak=%0d want pulse=1 bar=%0d peak=%0d",
                         vals[i], bus.update_pulse, bus.bar_level, bus.peak_level, want[i], e.peak);
            end
        end
        bus.x = 7'd40;
        bus.y = 7'd2;
        #1;
        total++;
        if (bus.oled_data !== 16'hF800) begin
            bad++;
            $display("FAIL quant_pixel_red: oled=%h want f800", bus.oled_data);
        end
    endtask

    task automatic test_attack_decay();
        exp_t e;
        do_reset();
        drive_window(1024, 1'b1, 1'b0);
        e = exp_q.pop_front();
        bus.x = 7'd40;
        bus.y = 7'd35;
        #1;
        total++;
        if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'd5 || bus.oled_data !== 16'hFFE0) begin
            bad++;
            $display("FAIL attack: pulse=%b bar=%0d oled=%h want 1 5 ffe0", bus.update_pulse, bus.bar_level, bus.oled_data);
        end
        for (int i = 1; i <= 5; i++) begin
            drive_window(0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            #1;
            total++;
            if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'(5 - i) || bus.peak_level !== 4'(e.peak)
                || bus.oled_data !== pix_model(40, 35, e.bar, e.peak)) begin
                bad++;
                $display("FAIL decay_%0d: pulse=%b bar=%0d peak=%0d oled=%h want 1 %0d %0d %h", i, bus.update_pulse,
                         bus.bar_level, bus.peak_level, bus.oled_data, 5 - i, e.peak, pix_model(40, 35, e.bar, e.peak));
            end
        end
    endtask

    task automatic test_peak_hold();
        int   want_peak[8] = '{9, 9, 8, 7, 6, 5, 4, 3};
        exp_t e;
        do_reset();
        drive_window(1842, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (bus.bar_level !== 4'd9 || bus.peak_level !== 4'd9) begin
            bad++;
            $display("FAIL peak_attack: bar=%0d peak=%0d want 9 9", bus.bar_level, bus.peak_level);
        end
        bus.x = 7'd32;
        bus.y = 7'd7;
        for (int i = 0; i < 8; i++) begin
            drive_window(0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            #1;
            total++;
            if (bus.update_pulse !== 1'b1 || bus.peak_level !== 4'(want_peak[i]) || bus.bar_level !== 4'(e.bar)
                || bus.peak_level < bus.bar_level || bus.oled_data !== pix_model(32, 7, e.bar, want_peak[i])) begin
                bad++;
                $display("FAIL peak_hold_%0d: bar=%0d peak=%0d oled=%h want bar=%0d peak=%0d oled=%h", i,
                         bus.bar_level, bus.peak_level, bus.oled_data, e.bar, want_peak[i], pix_model(32, 7, e.bar, want_peak[i]));
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        do_reset();
        drive_window(1434, 1'b1, 1'b1);
        e = exp_q.pop_front();
        total++;
        if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'd7 || bus.peak_level !== 4'd7) begin
            bad++;
            $display("FAIL collision_included: bar=%0d peak=%0d want 7 7", bus.bar_level, bus.peak_level);
        end
        drive_window(0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'd6 || bus.peak_level !== 4'(e.peak)) begin
            bad++;
            $display("FAIL collision_next_window: bar=%0d peak=%0d want 6 %0d", bus.bar_level, bus.peak_level, e.peak);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n;
        do_reset();
        drive_window(1300, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (bus.bar_level !== 4'd6) begin
            bad++;
            $display("FAIL async_setup: bar=%0d want 6", bus.bar_level);
        end
        bus.sample_valid = 1'b1;
        bus.sample       = 11'd2047;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.x = 7'd40;
        bus.y = 7'd30;
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (bus.bar_level !== 4'd0 || bus.peak_level !== 4'd0 || bus.oled_data !== 16'h0000) begin
            bad++;
            $display("FAIL async_clear: bar=%0d peak=%0d oled=%h want 0 0 0000", bus.bar_level, bus.peak_level, bus.oled_data);
        end
        @(negedge clk);
        reset  = 1'b0;
        m_bar  = 0;
        m_peak = 0;
        m_hold = 0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.update_pulse === 1'b1) break;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL async_first_update: after %0d cycles want 4", n);
        end
        total++;
        if (bus.bar_level !== 4'd0 || bus.peak_level !== 4'd0) begin
            bad++;
            $display("FAIL async_window_discarded: bar=%0d peak=%0d want 0 0", bus.bar_level, bus.peak_level);
        end
    endtask

    task automatic test_bounds();
        int          px[4]   = '{31, 64, 40, 63};
        int          py[4]   = '{60, 60, 57, 58};
        logic [15:0] want[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h07E0};
        exp_t        e;
        do_reset();
        drive_window(2047, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (bus.bar_level !== 4'd9) begin
            bad++;
            $display("FAIL bounds_setup: bar=%0d want 9", bus.bar_level);
        end
        for (int i = 0; i < 4; i++) begin
            bus.x = 7'(px[i]);
            bus.y = 7'(py[i]);
            #1;
            total++;
            if (bus.oled_data !== want[i]) begin
                bad++;
                $display("FAIL bounds_(%0d,%0d): oled=%h want %h", px[i], py[i], bus.oled_data, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   val, px, py;
        bit   vld, upd;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            val = $urandom_range(0, 2047);
            vld = ($urandom_range(0, 3) != 0);
            upd = 1'($urandom_range(0, 1));
            drive_window(val, vld, upd);
            e  = exp_q.pop_front();
            px = $urandom_range(28, 68);
            py = $urandom_range(0, 66);
            bus.x = 7'(px);
            bus.y = 7'(py);
            #1;
            total++;
            if (bus.update_pulse !== 1'b1 || bus.bar_level !== 4'(e.bar) || bus.peak_level !== 4'(e.peak)
                || bus.oled_data !== pix_model(px, py, e.bar, e.peak)) begin
                bad++;
                $display("FAIL b2b_%0d: bar=%0d peak=%0d oled=%h at (%0d,%0d) want %0d %0d %h", i, bus.bar_level,
                         bus.peak_level, bus.oled_data, px, py, e.bar, e.peak, pix_model(px, py, e.bar, e.peak));
            end
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.x            = '0;
        bus.y            = '0;
        m_bar  = 0;
        m_peak = 0;
        m_hold = 0;
        test_reset();
        test_quant();
        test_attack_decay();
        test_peak_hold();
        test_collision();
        test_async_reset();
        test_bounds();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
